// File: rtl/jt6295_rom_pkg.sv
// Shared types for the jt6295 sample-ROM arbiter: FSM states and counter sizing.
package jt6295_rom_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  // Width of the rom_ok settle counter; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned okdly);
    return (okdly == 0) ? 1 : $clog2(okdly + 1);
  endfunction

endpackage

// File: rtl/jt6295_rom_arb_if.sv
// Slot-side and ROM-side signals of the jt6295 sample-ROM arbiter.
// master: voice engines plus ROM controller; slave: the arbiter itself.
interface jt6295_rom_arb_if #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 18,
  parameter int unsigned DW    = 8
) ();

  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS*DW-1:0] slot_dout;
  logic [SLOTS-1:0]    slot_ok;
  logic [AW-1:0]       rom_addr;
  logic                rom_cs;
  logic [DW-1:0]       rom_data;
  logic                rom_ok;

  modport master (
    output slot_cs, slot_addr, rom_data, rom_ok,
    input  slot_dout, slot_ok, rom_addr, rom_cs
  );

  modport slave (
    input  slot_cs, slot_addr, rom_data, rom_ok,
    output slot_dout, slot_ok, rom_addr, rom_cs
  );

endinterface

// File: rtl/jt6295_rom_pick.sv
// Combinational grant selection over the pending slots.
// JT6295_ROM_RR_EN selects round-robin from rr_i; otherwise the lowest index wins.
module jt6295_rom_pick #(
  parameter int unsigned SLOTS = 4
) (
  input  logic [SLOTS-1:0]         pend_i,
`ifdef JT6295_ROM_RR_EN
  input  logic [$clog2(SLOTS)-1:0] rr_i,
`endif
  output logic [SLOTS-1:0]         gnt_o,
  output logic [$clog2(SLOTS)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(SLOTS);

`ifdef JT6295_ROM_RR_EN
  logic [IdxW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      j = IdxW'((32'(rr_i) + k) % SLOTS);
      if (gnt_o == '0 && pend_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    // Scan downward so the lowest pending index is the last one written.
    for (int unsigned k = SLOTS; k > 0; k--) begin
      if (pend_i[k-1]) begin
        gnt_o      = '0;
        gnt_o[k-1] = 1'b1;
        idx_o      = IdxW'(k - 1);
      end
    end
  end
`endif

endmodule

// File: rtl/jt6295_rom_arb.sv
// N-slot arbiter onto one shared sample ROM, with a one-entry hit cache per slot.
// Optional macro JT6295_ROM_RR_EN: round-robin arbitration instead of fixed priority.
module jt6295_rom_arb
  import jt6295_rom_pkg::*;
#(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 18,
  parameter int unsigned DW    = 8,
  parameter int unsigned OKDLY = 3
) (
  input logic             clk,
  input logic             rst,
  jt6295_rom_arb_if.slave bus_io
);

  localparam int unsigned     IdxW   = $clog2(SLOTS);
  localparam int unsigned     CntW   = cnt_width(OKDLY);
  localparam logic [CntW-1:0] CntMax = CntW'(OKDLY);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   req_addr_q, req_addr_d;
  logic [IdxW-1:0] req_slot_q, req_slot_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            rom_cs_q, rom_cs_d;
  logic            rom_good;

  logic [SLOTS-1:0] hit, pend, gnt;
  logic [IdxW-1:0]  win_idx;
  logic [AW-1:0]    addr [SLOTS];

`ifdef JT6295_ROM_RR_EN
  logic [IdxW-1:0] rr_q, rr_d;
`endif

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [AW-1:0] last_addr_q;
    logic [DW-1:0] dout_q;
    logic          valid_q;
    logic          ok_q, ok_d;
    logic          fill;

    assign addr[i] = bus_io.slot_addr[i*AW +: AW];
    assign hit[i]  = valid_q && (last_addr_q == addr[i]);
    assign pend[i] = bus_io.slot_cs[i] && !hit[i];
    assign fill    = rom_good && (req_slot_q == IdxW'(i));
    // Fetched data is always cached, but only reported if the slot still wants that address.
    assign ok_d    = hit[i] || (fill && (addr[i] == req_addr_q));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        last_addr_q <= '0;
        dout_q      <= '0;
        valid_q     <= 1'b0;
        ok_q        <= 1'b0;
      end else begin
        ok_q <= ok_d;
        if (fill) begin
          last_addr_q <= req_addr_q;
          dout_q      <= bus_io.rom_data;
          valid_q     <= 1'b1;
        end
      end
    end

    assign bus_io.slot_dout[i*DW +: DW] = dout_q;
    assign bus_io.slot_ok[i]            = ok_q;
  end

  jt6295_rom_pick #(
    .SLOTS(SLOTS)
  ) u_pick (
    .pend_i(pend),
`ifdef JT6295_ROM_RR_EN
    .rr_i  (rr_q),
`endif
    .gnt_o (gnt),
    .idx_o (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    req_slot_d = req_slot_q;
    rom_addr_d = rom_addr_q;
    rom_cs_d   = rom_cs_q;
    rom_good   = 1'b0;
`ifdef JT6295_ROM_RR_EN
    rr_d       = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          req_addr_d = addr[win_idx];
          req_slot_d = win_idx;
          rom_addr_d = addr[win_idx];
          rom_cs_d   = 1'b1;
          cnt_d      = '0;
          state_d    = StWait;
`ifdef JT6295_ROM_RR_EN
          rr_d       = (win_idx == IdxW'(SLOTS - 1)) ? '0 : win_idx + IdxW'(1);
`endif
        end
      end
      StWait: begin
        // Data is trusted only after OKDLY+1 back-to-back rom_ok samples.
        if (bus_io.rom_ok) begin
          if (cnt_q == CntMax) begin
            rom_good = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end else begin
          cnt_d = '0;
        end
        if (rom_good) begin
          rom_cs_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_slot_q <= '0;
      rom_addr_q <= '0;
      rom_cs_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_slot_q <= req_slot_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_q   <= rom_cs_d;
    end
  end

`ifdef JT6295_ROM_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign bus_io.rom_addr = rom_addr_q;
  assign bus_io.rom_cs   = rom_cs_q;

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Self-checking bench for jt6295_rom_arb: directed vector table, corner sequences, and
// randomized traffic against a slot/cache reference model.
module tb_jt6295_rom_arb;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned AW    = 18;
  localparam int unsigned DW    = 8;
  localparam int unsigned OKDLY = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jt6295_rom_arb_if #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) bus ();

  jt6295_rom_arb #(
    .SLOTS(SLOTS),
    .AW   (AW),
    .DW   (DW),
    .OKDLY(OKDLY)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [DW-1:0] rom_hash(logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h83;
  endfunction

  assign bus.rom_data = rom_hash(bus.rom_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] get_addr(int i);
    return bus.slot_addr[i*AW +: AW];
  endfunction

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.slot_addr[i*AW +: AW] = a;
  endtask

  // Reference model: per-slot cache contents, one outstanding fetch, run length of rom_ok.
  logic [AW-1:0]    m_last  [SLOTS];
  logic             m_valid [SLOTS];
  logic [DW-1:0]    m_dout  [SLOTS];
  logic [SLOTS-1:0] m_ok;
  bit               m_busy;
  int               m_slot, m_run, m_rr;
  logic [AW-1:0]    m_req, m_rom_addr;
  logic             m_rom_cs;

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_last[i]  = '0;
      m_valid[i] = 1'b0;
      m_dout[i]  = '0;
    end
    m_ok = '0; m_busy = 0; m_slot = 0; m_run = 0; m_rr = 0;
    m_req = '0; m_rom_addr = '0; m_rom_cs = 1'b0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [SLOTS-1:0] hit, ok_n;
    int w, s;
    for (int i = 0; i < SLOTS; i++) hit[i] = m_valid[i] && (m_last[i] == get_addr(i));
    ok_n = hit;
    if (m_busy) begin
      m_run = bus.rom_ok ? m_run + 1 : 0;
      if (m_run > int'(OKDLY)) begin
        m_last[m_slot]  = m_req;
        m_valid[m_slot] = 1'b1;
        m_dout[m_slot]  = rom_hash(m_req);
        if (get_addr(m_slot) == m_req) ok_n[m_slot] = 1'b1;
        m_busy   = 0;
        m_rom_cs = 1'b0;
      end
    end else begin
      w = -1;
      for (int k = 0; k < SLOTS; k++) begin
`ifdef JT6295_ROM_RR_EN
        s = (m_rr + k) % SLOTS;
`else
        s = k;
`endif
        if (w < 0 && bus.slot_cs[s] && !hit[s]) w = s;
      end
      if (w >= 0) begin
        m_busy = 1; m_slot = w; m_req = get_addr(w); m_run = 0;
        m_rom_addr = m_req; m_rom_cs = 1'b1;
        m_rr = (w + 1) % SLOTS;
      end
    end
    m_ok = ok_n;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic compare_model();
    check("rand rom_cs", bus.rom_cs, m_rom_cs);
    check("rand rom_addr", bus.rom_addr, m_rom_addr);
    check("rand slot_ok", bus.slot_ok, m_ok);
    for (int i = 0; i < SLOTS; i++)
      check($sformatf("rand slot_dout%0d", i), bus.slot_dout[i*DW +: DW], m_dout[i]);
  endtask

  task automatic drain();
    bit done = 0;
    bus.slot_cs = '0;
    bus.rom_ok  = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      done = !bus.rom_cs;
    end
    check("drain idle", done, 1);
  endtask

  typedef struct {
    logic          cs;
    logic [AW-1:0] addr;
    logic          rok;
    logic          e_cs;
    logic [AW-1:0] e_addr;
    logic          e_ok;
    logic [DW-1:0] e_dout;
  } vec_t;

  function automatic vec_t mk(logic cs, logic [AW-1:0] a, logic rok, logic ecs,
                              logic [AW-1:0] ea, logic eok, logic [DW-1:0] ed);
    vec_t v;
    v.cs = cs; v.addr = a; v.rok = rok;
    v.e_cs = ecs; v.e_addr = ea; v.e_ok = eok; v.e_dout = ed;
    return v;
  endfunction

  vec_t vt [20];
  int   exp_order [4];
  int   grants [$];
  bit   prev_cs, done;

  initial begin
    // Slot 2: miss, hits, address change, then a glitchy rom_ok run.
    vt[0]  = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'h00);
    vt[1]  = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'h00);
    vt[2]  = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'h00);
    vt[3]  = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'h00);
    vt[4]  = mk(1, 18'h1234, 1, 0, 18'h1234, 1, 8'hA5);
    vt[5]  = mk(1, 18'h1234, 1, 0, 18'h1234, 1, 8'hA5);
    vt[6]  = mk(1, 18'h1234, 1, 0, 18'h1234, 1, 8'hA5);
    vt[7]  = mk(1, 18'h1235, 1, 1, 18'h1235, 0, 8'hA5);
    vt[8]  = mk(1, 18'h1235, 1, 1, 18'h1235, 0, 8'hA5);
    vt[9]  = mk(1, 18'h1235, 1, 1, 18'h1235, 0, 8'hA5);
    vt[10] = mk(1, 18'h1235, 1, 1, 18'h1235, 0, 8'hA5);
    vt[11] = mk(1, 18'h1235, 1, 0, 18'h1235, 1, 8'hA4);
    vt[12] = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'hA4);
    vt[13] = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'hA4);
    vt[14] = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'hA4);
    vt[15] = mk(1, 18'h1234, 0, 1, 18'h1234, 0, 8'hA4);
    vt[16] = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'hA4);
    vt[17] = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'hA4);
    vt[18] = mk(1, 18'h1234, 1, 1, 18'h1234, 0, 8'hA4);
    vt[19] = mk(1, 18'h1234, 1, 0, 18'h1234, 1, 8'hA5);
`ifdef JT6295_ROM_RR_EN
    exp_order = '{0, 1, 3, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif

    bus.slot_cs = '0; bus.slot_addr = '0; bus.rom_ok = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset rom_cs", bus.rom_cs, 0);
    check("reset rom_addr", bus.rom_addr, 0);
    check("reset slot_ok", bus.slot_ok, 0);
    check("reset slot_dout", bus.slot_dout, 0);
    rst = 1'b0;

    // Contention: slots 0,1,3 keep changing address so they never hit and stay pending.
    bus.rom_ok = 1'b1;
    prev_cs = bus.rom_cs;
    for (int cyc = 0; cyc < 200 && grants.size() < 4; cyc++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (i != 2) begin
          bus.slot_cs[i] = 1'b1;
          set_addr(i, {2'(i), 16'(cyc)});
        end
      end
      cycle();
      if (bus.rom_cs && !prev_cs) grants.push_back(int'(bus.rom_addr[17:16]));
      prev_cs = bus.rom_cs;
    end
    check("contention grant count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++)
      check($sformatf("contention grant%0d", k), grants[k], exp_order[k]);
    drain();

    for (int k = 0; k < 20; k++) begin
      bus.slot_cs[2] = vt[k].cs;
      set_addr(2, vt[k].addr);
      bus.rom_ok = vt[k].rok;
      cycle();
      check($sformatf("vec%0d rom_cs", k), bus.rom_cs, vt[k].e_cs);
      check($sformatf("vec%0d rom_addr", k), bus.rom_addr, vt[k].e_addr);
      check($sformatf("vec%0d slot_ok2", k), bus.slot_ok[2], vt[k].e_ok);
      check($sformatf("vec%0d slot_dout2", k), bus.slot_dout[2*DW +: DW], vt[k].e_dout);
    end
    bus.slot_cs = '0;

    // Stale data: slot 1 moves away from 0x100 while its fetch is in flight.
    bus.rom_ok = 1'b1;
    bus.slot_cs[1] = 1'b1;
    set_addr(1, 18'h100);
    cycle();
    check("stale req rom_cs", bus.rom_cs, 1);
    check("stale req rom_addr", bus.rom_addr, 18'h100);
    set_addr(1, 18'h200);
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      cycle();
      done = !bus.rom_cs;
    end
    check("stale completion", done, 1);
    check("stale slot_ok1", bus.slot_ok[1], 0);
    check("stale slot_dout1", bus.slot_dout[1*DW +: DW], rom_hash(18'h100));
    bus.slot_cs[1] = 1'b0;
    set_addr(1, 18'h100);
    cycle();
    check("stale cached hit ok1", bus.slot_ok[1], 1);
    check("stale cached hit no rom_cs", bus.rom_cs, 0);
    bus.slot_cs[1] = 1'b1;
    set_addr(1, 18'h200);
    cycle();
    check("stale rerequest rom_cs", bus.rom_cs, 1);
    check("stale rerequest rom_addr", bus.rom_addr, 18'h200);
    drain();

    // Slot 2 hits while slot 3 misses; then asynchronous reset in the middle of WAIT.
    bus.rom_ok = 1'b0;
    bus.slot_cs[2] = 1'b1;
    set_addr(2, 18'h1234);
    bus.slot_cs[3] = 1'b1;
    set_addr(3, 18'h3333);
    cycle();
    check("mix rom_addr", bus.rom_addr, 18'h3333);
    check("mix rom_cs", bus.rom_cs, 1);
    check("mix hit ok2", bus.slot_ok[2], 1);
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    check("async rst rom_cs", bus.rom_cs, 0);
    check("async rst rom_addr", bus.rom_addr, 0);
    check("async rst slot_ok", bus.slot_ok, 0);
    check("async rst slot_dout", bus.slot_dout, 0);
    model_reset();
    #1 rst = 1'b0;
    bus.slot_cs[3] = 1'b0;
    bus.rom_ok = 1'b1;
    cycle();
    check("post rst miss rom_cs", bus.rom_cs, 1);
    check("post rst miss rom_addr", bus.rom_addr, 18'h1234);
    check("post rst miss ok2", bus.slot_ok[2], 0);
    repeat (4) cycle();
    check("post rst fill ok2", bus.slot_ok[2], 1);
    check("post rst fill dout2", bus.slot_dout[2*DW +: DW], 8'hA5);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < SLOTS; i++) begin
        bus.slot_cs[i] = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 3) == 0) set_addr(i, AW'($urandom_range(0, 5)));
      end
      bus.rom_ok = ($urandom_range(0, 3) != 0);
      cycle();
      compare_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jt6295_rom_arb.md
Name: jt6295_rom_arb

Overview:
N-slot arbiter between ADPCM/voice slots and one shared sample-ROM port. It generalises the two-slot fetcher in address width, data width, slot count and settle delay. It adds two things the two-slot version lacks: a one-entry per-slot hit cache, so a repeated address costs no ROM access, and stale-data protection. It sits between the jt6295 voice engines and the external ROM/SDRAM controller.

Parameters:
SLOTS, 4, number of requesting slots (2..8)
AW, 18, ROM address width
DW, 8, ROM data width
OKDLY, 3, consecutive rom_ok cycles required after the first one before data is trusted (0..7)

Ports:
clk  in  1  clock
rst  in  1  async reset, active-high
slot_cs  in  SLOTS  per-slot request strobe
slot_addr  in  SLOTS*AW  packed addresses; slot i at [i*AW +: AW]
slot_dout  out  SLOTS*DW  packed data per slot
slot_ok  out  SLOTS  data valid for the current slot_addr
rom_addr  out  AW  ROM address
rom_cs  out  1  ROM request active
rom_data  in  DW  ROM data
rom_ok  in  1  ROM data ready

Behaviour:
- Reset values:
  - rom_addr=0, rom_cs=0, slot_dout=0, slot_ok=0.
  - Per-slot last_addr=0 and valid=0.
  - FSM=IDLE, rr pointer=0, ok counter=0.
- Per-slot hit/miss, evaluated every cycle:
  - hit_i = valid_i && last_addr_i==slot_addr_i.
  - If !hit_i, slot_ok_i <= 0 on the next edge.
  - A slot with slot_cs_i && hit_i keeps slot_ok_i=1 and issues no ROM request.
- pend_i = slot_cs_i && !hit_i. pend_i is sampled only in IDLE; a cs pulse while the FSM is busy is lost unless cs is held.
- FSM IDLE:
  - If any pend_i, select the winner w (see Optional Feature).
  - Latch req_addr=slot_addr_w and req_slot=w.
  - Drive rom_addr=slot_addr_w, rom_cs=1, clear the counter, go to WAIT.
  - The request leaves one cycle after pend is seen.
- FSM WAIT:
  - Counter increments on rom_ok=1 and resets to 0 on rom_ok=0; saturates at OKDLY.
  - rom_good = rom_ok && counter==OKDLY, i.e. OKDLY+1 consecutive rom_ok samples.
  - On rom_good: rom_cs<=0, go to IDLE, and store last_addr_w=req_addr, valid_w=1, slot_dout_w=rom_data.
  - slot_ok_w<=1 only if slot_addr_w==req_addr in that cycle. Otherwise the data is cached under req_addr, slot_ok_w stays 0, and the slot re-requests from IDLE.
- Minimum miss latency: request cycle + (OKDLY+1) cycles to slot_ok.
- No back-to-back overlap: IDLE always costs one cycle between grants.
- Reset mid-WAIT: everything returns to reset values at once; an in-flight rom_data is discarded.
- Simultaneous hit and miss on different slots: the hit slot keeps slot_ok; the miss slot proceeds normally.
- Address change on a slot that is not the current winner: slot_ok_i drops the next cycle; valid_i is unchanged.

Optional Feature:
JT6295_ROM_RR_EN
- Defined: round-robin arbitration. The winner is the first pending slot at or after rr, scanning upward with wrap at SLOTS. On grant, rr<=w+1 mod SLOTS.
- Undefined: fixed priority, lowest index wins. The rr register is not built. This reproduces the two-slot behaviour where slot 0 beats slot 1.

Decomposition:
- Package jt6295_rom_pkg: FSM state enum {IDLE, WAIT} and the localparam for the counter width, clog2(OKDLY+1).
- One sub-module, jt6295_rom_pick: combinational pending vector + rr pointer -> one-hot grant and index. It contains both arbitration variants under the macro.
- Per-slot cache lives inline in a generate loop.

Test Plan:
- Single miss, SLOTS=4, OKDLY=3: slot2 addr=0x1234, ROM returns 0xA5 with rom_ok held -> rom_addr=0x1234 one cycle after cs; slot_ok[2]=1 and slot_dout[2]=0xA5 four cycles after rom_cs rises.
- Hit: re-assert slot2 cs with addr 0x1234 -> rom_cs stays 0, slot_ok[2] stays 1. Change to 0x1235 -> slot_ok[2] drops the next cycle and a new ROM request is issued.
- rom_ok glitch: pattern 1,1,0,1,1,1,1 -> data is captured only on the 7th cycle, not earlier.
- Contention: slots 0,1,3 pend continuously. With JT6295_ROM_RR_EN, grant order is 0,1,3,0. Without it, slot 0 wins every time it is pending.
- Stale data: slot1 addr changes from 0x100 to 0x200 during WAIT -> on completion slot_ok[1]=0 and last_addr_1=0x100, followed by a new request to 0x200.
- Async reset mid-WAIT -> rom_cs, all slot_ok and valid clear immediately without waiting for clk; the first post-reset request behaves as a miss.
